// File: rtl/av2_deblock_edge_feeder.sv
// rtl/av2_deblock_edge_feeder.sv - raster pixel stream to 8-pixel vertical-edge deblocking segments
// Define AV2_DBF_FEED_SKIP_FLAT_EN to suppress all-equal segments and count them in skip_cnt.
module av2_deblock_edge_feeder #(
  parameter int MAX_WIDTH  = 128,
  parameter int MAX_HEIGHT = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] frame_width,
  input  logic [15:0] frame_height,
  input  logic        start,
  output logic        busy,
  output logic        done,
  input  logic [9:0]  in_pixel,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [79:0] seg_pixels,
  output logic [15:0] seg_x,
  output logic [15:0] seg_y,
  output logic        seg_valid,
  input  logic        seg_ready,
  output logic [15:0] skip_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [15:0] W_LIMIT = 16'(MAX_WIDTH);
  localparam logic [15:0] H_LIMIT = 16'(MAX_HEIGHT);

  state_t      state, state_next;
  logic [15:0] w, h, x, y;
  logic [15:0] w_in, h_in;
  // Seven prior pixels of the row; the incoming pixel completes the 8-wide window.
  logic [69:0] hist;
  logic [79:0] window;
  logic        start_acc, accept, last_x, last_px, eligible, emit;

  assign w_in      = (frame_width  > W_LIMIT) ? W_LIMIT : frame_width;
  assign h_in      = (frame_height > H_LIMIT) ? H_LIMIT : frame_height;
  assign window    = {in_pixel, hist};
  assign start_acc = (state == IDLE) && start;
  assign in_ready  = !rst && (state == RUN) && !(seg_valid && !seg_ready);
  assign accept    = in_valid && in_ready;
  assign busy      = !rst && (state != IDLE);
  assign last_x    = (x == w - 16'd1);
  assign last_px   = last_x && (y == h - 16'd1);
  // The q block (seg_x..seg_x+7) must lie entirely inside the row.
  assign eligible  = (x[2:0] == 3'd3) && (x >= 16'd11) &&
                     (({1'b0, x} + 17'd5) <= {1'b0, w});

`ifdef AV2_DBF_FEED_SKIP_FLAT_EN
  logic        flat;
  logic [15:0] skip_q;

  always_comb begin
    flat = 1'b1;
    for (int k = 1; k < 8; k++) begin
      if (window[k*10 +: 10] != window[9:0]) flat = 1'b0;
    end
  end

  assign emit     = eligible && !flat;
  assign skip_cnt = skip_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      skip_q <= '0;
    end else if (start_acc) begin
      skip_q <= '0;
    end else if (accept && eligible && flat && (skip_q != 16'hFFFF)) begin
      skip_q <= skip_q + 16'd1;
    end
  end
`else
  assign emit     = eligible;
  assign skip_cnt = '0;
`endif

  always_comb begin
    state_next = state;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = ((w_in == 16'd0) || (h_in == 16'd0)) ? DRAIN : RUN;
        end
      end
      RUN: begin
        if (accept && last_px) state_next = DRAIN;
      end
      DRAIN: begin
        if (!seg_valid) begin
          state_next = IDLE;
          done       = !rst;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      w          <= '0;
      h          <= '0;
      x          <= '0;
      y          <= '0;
      hist       <= '0;
      seg_valid  <= 1'b0;
      seg_pixels <= '0;
      seg_x      <= '0;
      seg_y      <= '0;
    end else begin
      state <= state_next;
      if (start_acc) begin
        w    <= w_in;
        h    <= h_in;
        x    <= '0;
        y    <= '0;
        hist <= '0;
      end
      if (accept) begin
        hist <= last_x ? 70'd0 : window[79:10];
        x    <= last_x ? 16'd0 : x + 16'd1;
        if (last_x) y <= y + 16'd1;
      end
      // A new segment may load in the same cycle the previous one is handed off.
      if (accept && emit) begin
        seg_valid  <= 1'b1;
        seg_pixels <= window;
        seg_x      <= x - 16'd3;
        seg_y      <= y;
      end else if (seg_valid && seg_ready) begin
        seg_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_av2_deblock_edge_feeder.sv
// tb/tb_av2_deblock_edge_feeder.sv - randomized and directed bench against a frame-level segment model
module tb_av2_deblock_edge_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] frame_width, frame_height;
  logic        start, busy, done;
  logic [9:0]  in_pixel;
  logic        in_valid, in_ready;
  logic [79:0] seg_pixels;
  logic [15:0] seg_x, seg_y;
  logic        seg_valid, seg_ready;
  logic [15:0] skip_cnt;

  always #5 clk = ~clk;

  av2_deblock_edge_feeder dut (
    .clk(clk), .rst(rst), .frame_width(frame_width), .frame_height(frame_height),
    .start(start), .busy(busy), .done(done), .in_pixel(in_pixel), .in_valid(in_valid),
    .in_ready(in_ready), .seg_pixels(seg_pixels), .seg_x(seg_x), .seg_y(seg_y),
    .seg_valid(seg_valid), .seg_ready(seg_ready), .skip_cnt(skip_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  int unsigned px[$];
  logic [79:0] exp_pix[$];
  int          exp_x[$];
  int          exp_y[$];
  int          exp_skip;
  int          exp_total;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_seg_valid"}, seg_valid, 0);
    check({tag, "_seg_pixels"}, seg_pixels, 0);
    check({tag, "_seg_x"}, seg_x, 0);
    check({tag, "_seg_y"}, seg_y, 0);
    check({tag, "_skip_cnt"}, skip_cnt, 0);
  endtask

  // Frame model: every edge at a multiple of 8 whose full 8-column q block fits in the row
  // gets a segment of the four columns on each side.
  task automatic build(input int w, input int h, input int mode);
    logic [31:0] mask;
    int unsigned base;
    logic [79:0] s;
    bit          flat;
    px.delete(); exp_pix.delete(); exp_x.delete(); exp_y.delete();
    exp_skip = 0;
    for (int yy = 0; yy < h; yy++) begin
      mask = $urandom;
      base = $urandom_range(0, 1023);
      for (int xx = 0; xx < w; xx++) begin
        case (mode)
          0: px.push_back((xx * 4) % 1024);
          1: px.push_back($urandom_range(0, 1023));
          2: px.push_back(128);
          default: px.push_back(mask[(xx / 4) % 32] ? base : $urandom_range(0, 1023));
        endcase
      end
    end
    for (int yy = 0; yy < h; yy++) begin
      for (int e = 8; e + 8 <= w; e += 8) begin
        flat = 1'b1;
        for (int k = 0; k < 8; k++) begin
          s[k*10 +: 10] = 10'(px[yy * w + e - 4 + k]);
          if (px[yy * w + e - 4 + k] != px[yy * w + e - 4]) flat = 1'b0;
        end
`ifdef AV2_DBF_FEED_SKIP_FLAT_EN
        if (flat) begin
          exp_skip++;
          continue;
        end
`endif
        exp_pix.push_back(s);
        exp_x.push_back(e);
        exp_y.push_back(yy);
      end
    end
    exp_total = exp_pix.size();
  endtask

  // rmode 0: always ready, 1: random valid/ready, 2: first segment stalled 20 cycles.
  task automatic run_frame(input int w, input int h, input int mode, input int rmode, output int got);
    int pi, cyc, dones, hold, n;
    build(w, h, mode);
    n = px.size();
    got = 0; pi = 0; cyc = 0; dones = 0; hold = 0;
    @(negedge clk);
    rst = 1'b0;
    frame_width = w[15:0];
    frame_height = h[15:0];
    start = 1'b1;
    in_valid = 1'b0;
    seg_ready = 1'b1;
    while (dones == 0 && cyc < 20000) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      case (rmode)
        0: seg_ready = 1'b1;
        1: seg_ready = ($urandom_range(0, 2) != 0);
        default: begin
          if (seg_valid && hold < 20) begin
            seg_ready = 1'b0;
            hold++;
          end else begin
            seg_ready = 1'b1;
          end
        end
      endcase
      in_valid = (pi < n) && ((rmode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1);
      in_pixel = (pi < n) ? 10'(px[pi]) : 10'($urandom);
      #1;
      if (cyc == 1) check("busy_after_start", busy, 1);
      if (seg_valid) begin
        if (exp_pix.size() == 0) begin
          check("extra_seg", got + 1, exp_total);
        end else begin
          check("seg_pixels", seg_pixels, exp_pix[0]);
          check("seg_x", seg_x, exp_x[0]);
          check("seg_y", seg_y, exp_y[0]);
          if (seg_ready) begin
            void'(exp_pix.pop_front());
            void'(exp_x.pop_front());
            void'(exp_y.pop_front());
            got++;
          end
        end
        if (!seg_ready) check("stall_in_ready", in_ready, 0);
      end
      if (w == 0 || h == 0) check("empty_in_ready", in_ready, 0);
      if (in_valid && in_ready) pi++;
      if (done) begin
        dones++;
        check("segs_before_done", exp_pix.size(), 0);
        check("px_before_done", pi, n);
      end
    end
    check("done_seen", dones, 1);
    check("skip_cnt", skip_cnt, exp_skip);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("done_one_cycle", done, 0);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    int got;
    int pi;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_pixel = '0; seg_ready = 1'b0;
    frame_width = '0; frame_height = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check_reset_outputs("por");

    run_frame(16, 2, 0, 0, got);
    check("w16_seg_count", got, 2);
    run_frame(32, 1, 0, 2, got);
    check("stall_seg_count", got, 3);
    run_frame(0, 5, 0, 0, got);
    check("empty_seg_count", got, 0);
    run_frame(20, 1, 1, 0, got);
    check("partial_seg_count", got, 1);
    run_frame(16, 4, 2, 0, got);
`ifdef AV2_DBF_FEED_SKIP_FLAT_EN
    check("flat_seg_count", got, 0);
    check("flat_skip_cnt", skip_cnt, 4);
`else
    check("flat_seg_count", got, 4);
    check("flat_skip_cnt", skip_cnt, 0);
`endif

    // Abandon a frame with reset just before column 10 is accepted.
    @(negedge clk);
    frame_width = 16'd32; frame_height = 16'd2; start = 1'b1; seg_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pi = 0;
    for (int k = 0; k < 50 && pi < 10; k++) begin
      in_valid = 1'b1;
      in_pixel = 10'(pi * 4);
      #1;
      if (in_ready) pi++;
      @(negedge clk);
    end
    check("mid_accepts", pi, 10);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    check_reset_outputs("mid_rst");
    @(negedge clk);
    #1;
    check_reset_outputs("mid_rst2");
    run_frame(16, 1, 0, 0, got);
    check("after_rst_seg_count", got, 1);

    for (int f = 0; f < 8; f++) begin
      run_frame($urandom_range(0, 72), $urandom_range(0, 4), $urandom_range(0, 3), 1, got);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
